// File: rtl/stepper_pkg.sv
// Shared widths, FSM state type and half-period helper for the step pulse generator.
package stepper_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = DATA_WIDTH - 1;
    localparam int unsigned DIR_BIT    = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_e;

    // A programmed half-period of zero behaves as one clock.
    function automatic logic [DATA_WIDTH-1:0] eff_half_period(input logic [DATA_WIDTH-1:0] hp);
        return (hp == '0) ? DATA_WIDTH'(1) : hp;
    endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Configuration, control and status bundle between the register block and the step pulse generator.
interface step_pulse_gen_if;
    import stepper_pkg::*;

    logic [DATA_WIDTH-1:0] half_period_in;
    logic [DATA_WIDTH-1:0] cmd_in;
    logic                  start_in;
    logic                  abort_in;
    logic                  step_out;
    logic                  dir_out;
    logic                  busy_out;
    logic                  done_out;
    logic [CNT_WIDTH-1:0]  steps_left_out;

    modport master (
        output half_period_in, cmd_in, start_in, abort_in,
        input  step_out, dir_out, busy_out, done_out, steps_left_out
    );

    modport slave (
        input  half_period_in, cmd_in, start_in, abort_in,
        output step_out, dir_out, busy_out, done_out, steps_left_out
    );

endinterface

// File: rtl/half_period_timer.sv
// Loadable down-counter that paces each phase of the step waveform.
module half_period_timer
    import stepper_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  load_in,
    input  logic [DATA_WIDTH-1:0] load_val_in,
    input  logic                  en_in,
    output logic                  zero_c
);

    logic [DATA_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_in) begin
            cnt_d = load_val_in;
        end else if (en_in && (cnt_q != '0)) begin
            cnt_d = cnt_q - DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Emits a bounded STEP pulse train with DIR setup for an external stepper driver.
module step_pulse_gen
    import stepper_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    step_pulse_gen_if.slave    bus
);

    state_e                state_q, state_d;
    logic                  step_q, step_d;
    logic                  dir_q, dir_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  left_q, left_d;
    logic [DATA_WIDTH-1:0] p_q, p_d;

    logic                  tmr_load_c;
    logic [DATA_WIDTH-1:0] tmr_val_c;
    logic                  tmr_zero_c;
    logic [CNT_WIDTH-1:0]  n_c;
    logic [DATA_WIDTH-1:0] p_start_c;

    assign n_c       = bus.cmd_in[CNT_WIDTH-1:0];
    assign p_start_c = eff_half_period(bus.half_period_in);

    half_period_timer u_timer (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .load_in     (tmr_load_c),
        .load_val_in (tmr_val_c),
        .en_in       (state_q != IDLE),
        .zero_c      (tmr_zero_c)
    );

    // Next-state and output decode; abort outranks phase expiry in every active state.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        dir_d      = dir_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        left_d     = left_q;
        p_d        = p_q;
        tmr_load_c = 1'b0;
        tmr_val_c  = p_q - DATA_WIDTH'(1);

        if (state_q == IDLE) begin
            if (bus.start_in && !bus.abort_in) begin
                if (n_c != '0) begin
                    p_d        = p_start_c;
                    dir_d      = bus.cmd_in[DIR_BIT];
                    busy_d     = 1'b1;
                    left_d     = n_c;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = p_start_c - DATA_WIDTH'(1);
                    state_d    = SETUP;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (bus.abort_in) begin
            step_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
        end else if (tmr_zero_c) begin
            unique case (state_q)
                SETUP: begin
                    step_d     = 1'b1;
                    tmr_load_c = 1'b1;
                    state_d    = HIGH;
                end
                HIGH: begin
                    step_d     = 1'b0;
                    tmr_load_c = 1'b1;
                    state_d    = LOW;
                end
                LOW: begin
                    left_d = left_q - CNT_WIDTH'(1);
                    if (left_q == CNT_WIDTH'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        step_d     = 1'b1;
                        tmr_load_c = 1'b1;
                        state_d    = HIGH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            left_q  <= '0;
            p_q     <= DATA_WIDTH'(1);
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            left_q  <= left_d;
            p_q     <= p_d;
        end
    end

    assign bus.step_out       = step_q;
    assign bus.dir_out        = dir_q;
    assign bus.busy_out       = busy_q;
    assign bus.done_out       = done_q;
    assign bus.steps_left_out = left_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: per-cycle expected outputs queued at stimulus time, compared at negedge.
module tb_step_pulse_gen;
    import stepper_pkg::*;

    localparam int unsigned CW = CNT_WIDTH;

    typedef struct packed {
        logic          step;
        logic          dir;
        logic          busy;
        logic          done;
        logic [CW-1:0] left;
    } obs_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    obs_t exp_q[$];
    logic          cur_dir;
    logic [CW-1:0] cur_left;

    step_pulse_gen_if bus ();

    step_pulse_gen dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_idle(input int n);
        obs_t r;
        for (int i = 0; i < n; i++) begin
            r.step = 1'b0; r.dir = cur_dir; r.busy = 1'b0; r.done = 1'b0; r.left = cur_left;
            exp_q.push_back(r);
        end
    endtask

    task automatic push_done_only();
        obs_t r;
        r.step = 1'b0; r.dir = cur_dir; r.busy = 1'b0; r.done = 1'b1; r.left = cur_left;
        exp_q.push_back(r);
    endtask

    // Waveform model: cycle k after the start edge; abort_k>0 means abort is held during cycle abort_k.
    task automatic push_move(input int p, input int n, input logic d, input int abort_k);
        obs_t r;
        int   total;
        total = p + 2 * p * n;
        for (int k = 1; k <= total; k++) begin
            r.busy = 1'b1;
            r.dir  = d;
            r.done = 1'b0;
            r.step = (k > p) && (((k - p - 1) % (2 * p)) < p);
            r.left = CW'(n - ((k > p) ? (k - p - 1) / (2 * p) : 0));
            exp_q.push_back(r);
            if (k == abort_k) begin
                r.step = 1'b0;
                r.busy = 1'b0;
                exp_q.push_back(r);
                cur_dir  = d;
                cur_left = r.left;
                return;
            end
        end
        r.step = 1'b0; r.dir = d; r.busy = 1'b0; r.done = 1'b1; r.left = '0;
        exp_q.push_back(r);
        cur_dir  = d;
        cur_left = '0;
    endtask

    task automatic check_cycles(input int n, input string tag);
        obs_t o;
        obs_t e;
        for (int i = 0; i < n; i++) begin
            o.step = bus.step_out; o.dir = bus.dir_out; o.busy = bus.busy_out;
            o.done = bus.done_out; o.left = bus.steps_left_out;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL %s[%0d]: scoreboard empty, observed step=%b busy=%b", tag, i, o.step, o.busy);
            end else begin
                e = exp_q.pop_front();
                assert (o === e) else begin
                    failures++;
                    $error("FAIL %s[%0d]: observed step=%b dir=%b busy=%b done=%b left=%0d expected step=%b dir=%b busy=%b done=%b left=%0d",
                           tag, i, o.step, o.dir, o.busy, o.done, o.left, e.step, e.dir, e.busy, e.done, e.left);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic start_move(input int hp, input logic d, input int n);
        bus.half_period_in = DATA_WIDTH'(hp);
        bus.cmd_in         = {d, CW'(n)};
        bus.start_in       = 1'b1;
        check_cycles(1, "start");
        bus.start_in       = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cur_dir  = 1'b0;
        cur_left = '0;
        rst_n    = 1'b0;
        bus.half_period_in = '0;
        bus.cmd_in         = '0;
        bus.start_in       = 1'b0;
        bus.abort_in       = 1'b0;

        // Reset values, then idle after release.
        @(negedge clk);
        push_idle(1);
        check_cycles(1, "reset");
        rst_n = 1'b1;
        push_idle(2);
        check_cycles(2, "idle");

        // P=3, N=2, DIR=1.
        push_idle(1);
        push_move(3, 2, 1'b1, 0);
        push_idle(2);
        start_move(3, 1'b1, 2);
        check_cycles(18, "p3n2");

        // Zero half-period behaves as one.
        push_idle(1);
        push_move(1, 1, 1'b0, 0);
        push_idle(1);
        start_move(0, 1'b0, 1);
        check_cycles(5, "p0n1");

        // P=2, N=5: restart while busy is ignored, abort during the third HIGH phase.
        push_idle(1);
        push_move(2, 5, 1'b1, 11);
        push_idle(2);
        start_move(2, 1'b1, 5);
        check_cycles(2, "p2n5");
        bus.cmd_in   = {1'b0, CW'(9)};
        bus.start_in = 1'b1;
        check_cycles(1, "restart_busy");
        bus.start_in = 1'b0;
        check_cycles(7, "p2n5");
        bus.abort_in = 1'b1;
        check_cycles(1, "abort_cyc");
        bus.abort_in = 1'b0;
        check_cycles(3, "after_abort");

        // N=0 gives a lone done pulse; DIR and remaining count hold.
        push_idle(1);
        push_done_only();
        push_idle(1);
        start_move(5, 1'b0, 0);
        check_cycles(2, "n0");

        // Start together with abort in IDLE is dropped.
        push_idle(3);
        bus.half_period_in = 32'd2;
        bus.cmd_in         = {1'b0, CW'(4)};
        bus.start_in       = 1'b1;
        bus.abort_in       = 1'b1;
        check_cycles(1, "start_abort");
        bus.start_in       = 1'b0;
        bus.abort_in       = 1'b0;
        check_cycles(2, "start_abort");

        // Inputs changed mid-move are ignored until the next start.
        push_idle(1);
        push_move(2, 3, 1'b0, 0);
        push_idle(1);
        start_move(2, 1'b0, 3);
        check_cycles(3, "p2n3");
        bus.half_period_in = 32'd4;
        bus.cmd_in         = {1'b1, CW'(2)};
        check_cycles(13, "p2n3_chg");
        push_idle(1);
        push_move(4, 2, 1'b1, 0);
        push_idle(1);
        bus.start_in = 1'b1;
        check_cycles(1, "restart");
        bus.start_in = 1'b0;
        check_cycles(22, "p4n2");

        // Asynchronous reset during HIGH.
        push_idle(1);
        push_move(3, 3, 1'b1, 0);
        start_move(3, 1'b1, 3);
        check_cycles(4, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (bus.step_out === 1'b0) else begin
            failures++;
            $error("FAIL rst_step: observed %b expected 0", bus.step_out);
        end
        checks++;
        assert (bus.busy_out === 1'b0) else begin
            failures++;
            $error("FAIL rst_busy: observed %b expected 0", bus.busy_out);
        end
        checks++;
        assert (bus.steps_left_out === CW'(0)) else begin
            failures++;
            $error("FAIL rst_left: observed %0d expected 0", bus.steps_left_out);
        end
        exp_q.delete();
        cur_dir  = 1'b0;
        cur_left = '0;
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(4);
        check_cycles(4, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
